// File: rtl/axi_tdd_ng_pkg.sv
// Shared types and constants for the axi_tdd_ng timing core.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

  localparam int unsigned MAX_PROFILES = 16;

endpackage

// File: rtl/axi_tdd_ng_profile_shadow.sv
// Capture/freeze registers for the asynchronous configuration and a
// registered lookup of the frame length for a selected profile.
module axi_tdd_ng_profile_shadow #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int NUM_PROFILES      = 4,
  parameter int PROFILE_IDX_WIDTH = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   load,
  input  logic [BURST_COUNT_WIDTH-1:0]           asy_tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]              asy_tdd_startup_delay,
  input  logic [NUM_PROFILES*REGISTER_WIDTH-1:0] asy_tdd_frame_length,
  input  logic [PROFILE_IDX_WIDTH:0]             asy_tdd_profile_count,
  input  logic [PROFILE_IDX_WIDTH-1:0]           len_sel,
  output logic [BURST_COUNT_WIDTH-1:0]           burst_count,
  output logic [REGISTER_WIDTH-1:0]              startup_delay,
  output logic [PROFILE_IDX_WIDTH:0]             profile_count,
  output logic [REGISTER_WIDTH-1:0]              cur_len
);

  localparam int PCW = PROFILE_IDX_WIDTH + 1;

  logic [REGISTER_WIDTH-1:0] len_q   [NUM_PROFILES];
  logic [REGISTER_WIDTH-1:0] len_nxt [NUM_PROFILES];
  logic [PCW-1:0]            pc_in;

  function automatic logic [REGISTER_WIDTH-1:0] nz_len(input logic [REGISTER_WIDTH-1:0] v);
    return (v == '0) ? REGISTER_WIDTH'(1) : v;
  endfunction

  // cur_len is looked up from the post-load view so it lines up with the
  // index the top registers in the same edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PROFILES; i++) begin
      len_nxt[i] = load ? nz_len(asy_tdd_frame_length[i*REGISTER_WIDTH +: REGISTER_WIDTH])
                        : len_q[i];
    end
  end

  always_comb begin
    pc_in = asy_tdd_profile_count;
    if (asy_tdd_profile_count == '0) begin
      pc_in = PCW'(1);
    end else if (asy_tdd_profile_count > PCW'(NUM_PROFILES)) begin
      pc_in = PCW'(NUM_PROFILES);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_count   <= '0;
      startup_delay <= '0;
      profile_count <= '0;
      len_q         <= '{default: '0};
      cur_len       <= '0;
    end else begin
      if (load) begin
        burst_count   <= asy_tdd_burst_count;
        startup_delay <= asy_tdd_startup_delay;
        profile_count <= pc_in;
      end
      len_q   <= len_nxt;
      cur_len <= len_nxt[len_sel];
    end
  end

endmodule

// File: rtl/axi_tdd_ng_profile_counter.sv
// TDD frame timing counter with cyclic frame-length profiles, burst
// counting, frame re-sync and optional automatic re-arm.
module axi_tdd_ng_profile_counter
  import axi_tdd_ng_pkg::*;
#(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int NUM_PROFILES      = 4,
  parameter int PROFILE_IDX_WIDTH = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   tdd_enable,
  input  logic                                   tdd_sync,
  input  logic                                   tdd_sync_rst,
  input  logic                                   tdd_auto_rearm,
  input  logic [BURST_COUNT_WIDTH-1:0]           asy_tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]              asy_tdd_startup_delay,
  input  logic [NUM_PROFILES*REGISTER_WIDTH-1:0] asy_tdd_frame_length,
  input  logic [PROFILE_IDX_WIDTH:0]             asy_tdd_profile_count,
  output logic                                   tdd_active,
  output logic [REGISTER_WIDTH-1:0]              tdd_counter,
  output state_t                                 tdd_cstate,
  output logic [PROFILE_IDX_WIDTH-1:0]           tdd_profile_idx,
  output logic                                   tdd_endof_frame,
  output logic                                   tdd_endof_burst,
  output logic [BURST_COUNT_WIDTH-1:0]           tdd_burst_counter
);

  localparam int PCW = PROFILE_IDX_WIDTH + 1;

  state_t                         state_q, state_d;
  logic [REGISTER_WIDTH-1:0]      cnt_q, cnt_d;
  logic [PROFILE_IDX_WIDTH-1:0]   idx_q, idx_d, idx_adv;
  logic [BURST_COUNT_WIDTH-1:0]   bc_q, bc_d;
  logic [PCW-1:0]                 idx_p1;

  logic [BURST_COUNT_WIDTH-1:0]   sh_burst;
  logic [REGISTER_WIDTH-1:0]      sh_delay;
  logic [PCW-1:0]                 sh_pcount;
  logic [REGISTER_WIDTH-1:0]      cur_len;

  logic shadow_load, eof, eob, restart;

  assign shadow_load = tdd_enable && ((state_q == IDLE) || (state_q == ARMED));

  axi_tdd_ng_profile_shadow #(
    .REGISTER_WIDTH    (REGISTER_WIDTH),
    .BURST_COUNT_WIDTH (BURST_COUNT_WIDTH),
    .NUM_PROFILES      (NUM_PROFILES),
    .PROFILE_IDX_WIDTH (PROFILE_IDX_WIDTH)
  ) u_shadow (
    .clk                   (clk),
    .resetn                (resetn),
    .load                  (shadow_load),
    .asy_tdd_burst_count   (asy_tdd_burst_count),
    .asy_tdd_startup_delay (asy_tdd_startup_delay),
    .asy_tdd_frame_length  (asy_tdd_frame_length),
    .asy_tdd_profile_count (asy_tdd_profile_count),
    .len_sel               (idx_d),
    .burst_count           (sh_burst),
    .startup_delay         (sh_delay),
    .profile_count         (sh_pcount),
    .cur_len               (cur_len)
  );

  // End markers decode registered state only; cur_len tracks idx_q.
  assign eof     = (state_q == RUNNING) && (cnt_q == cur_len - REGISTER_WIDTH'(1));
  assign eob     = eof && (bc_q == BURST_COUNT_WIDTH'(1));
  assign restart = tdd_sync && tdd_sync_rst;

  assign idx_p1  = {1'b0, idx_q} + PCW'(1);
  assign idx_adv = (idx_p1 >= sh_pcount) ? '0 : idx_p1[PROFILE_IDX_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tdd_enable) state_d = ARMED;
      end
      ARMED: begin
        cnt_d = '0;
        if (!tdd_enable) begin
          state_d = IDLE;
        end else if (tdd_sync) begin
          bc_d    = sh_burst;
          idx_d   = '0;
          state_d = (sh_delay == '0) ? RUNNING : WAITING;
        end
      end
      WAITING: begin
        if (!tdd_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (restart) begin
          cnt_d = '0;
        end else if (cnt_q == sh_delay - REGISTER_WIDTH'(1)) begin
          state_d = RUNNING;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + REGISTER_WIDTH'(1);
        end
      end
      RUNNING: begin
        if (restart) begin
          cnt_d = '0;
          idx_d = '0;
        end else if (eof) begin
          cnt_d = '0;
          idx_d = idx_adv;
          if (bc_q != '0) bc_d = bc_q - BURST_COUNT_WIDTH'(1);
          if (!tdd_enable) begin
            state_d = IDLE;
          end else if (eob) begin
            if (tdd_auto_rearm) begin
              bc_d    = sh_burst;
              idx_d   = '0;
              state_d = (sh_delay == '0) ? RUNNING : WAITING;
            end else begin
              state_d = ARMED;
            end
          end
        end else begin
          cnt_d = cnt_q + REGISTER_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
    end
  end

  assign tdd_active        = (state_q == RUNNING);
  assign tdd_counter       = cnt_q;
  assign tdd_cstate        = state_q;
  assign tdd_profile_idx   = idx_q;
  assign tdd_endof_frame   = eof;
  assign tdd_endof_burst   = eob;
  assign tdd_burst_counter = bc_q;

endmodule

// File: tb/tb_axi_tdd_ng_profile_counter.sv
// Bench for axi_tdd_ng_profile_counter: constant vectors, corner-case
// sequences and randomized configurations against a timeline model.
module tb_axi_tdd_ng_profile_counter;
  import axi_tdd_ng_pkg::*;

  localparam int RW  = 32;
  localparam int BW  = 32;
  localparam int NP  = 4;
  localparam int PIW = 2;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             tdd_enable = 1'b0;
  logic             tdd_sync = 1'b0;
  logic             tdd_sync_rst = 1'b0;
  logic             tdd_auto_rearm = 1'b0;
  logic [BW-1:0]    asy_tdd_burst_count = '0;
  logic [RW-1:0]    asy_tdd_startup_delay = '0;
  logic [NP*RW-1:0] asy_tdd_frame_length = '0;
  logic [PIW:0]     asy_tdd_profile_count = '0;
  logic             tdd_active;
  logic [RW-1:0]    tdd_counter;
  state_t           tdd_cstate;
  logic [PIW-1:0]   tdd_profile_idx;
  logic             tdd_endof_frame;
  logic             tdd_endof_burst;
  logic [BW-1:0]    tdd_burst_counter;

  int n_cmp = 0;
  int n_err = 0;

  int m_len [NP];
  int m_pc, m_burst, m_delay;
  bit m_rearm;

  axi_tdd_ng_profile_counter #(
    .REGISTER_WIDTH    (RW),
    .BURST_COUNT_WIDTH (BW),
    .NUM_PROFILES      (NP),
    .PROFILE_IDX_WIDTH (PIW)
  ) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .tdd_enable            (tdd_enable),
    .tdd_sync              (tdd_sync),
    .tdd_sync_rst          (tdd_sync_rst),
    .tdd_auto_rearm        (tdd_auto_rearm),
    .asy_tdd_burst_count   (asy_tdd_burst_count),
    .asy_tdd_startup_delay (asy_tdd_startup_delay),
    .asy_tdd_frame_length  (asy_tdd_frame_length),
    .asy_tdd_profile_count (asy_tdd_profile_count),
    .tdd_active            (tdd_active),
    .tdd_counter           (tdd_counter),
    .tdd_cstate            (tdd_cstate),
    .tdd_profile_idx       (tdd_profile_idx),
    .tdd_endof_frame       (tdd_endof_frame),
    .tdd_endof_burst       (tdd_endof_burst),
    .tdd_burst_counter     (tdd_burst_counter)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Profile index is only meaningful in RUNNING; burst counter in WAITING/RUNNING.
  task automatic check_out(input string tag, input state_t st, input int cnt, input int idx,
                           input bit eof, input bit eob, input int bc);
    cmp($sformatf("%s.state", tag), 64'(tdd_cstate), 64'(st));
    cmp($sformatf("%s.counter", tag), 64'(tdd_counter), 64'(cnt));
    cmp($sformatf("%s.active", tag), 64'(tdd_active), 64'(st == RUNNING));
    cmp($sformatf("%s.eof", tag), 64'(tdd_endof_frame), 64'(eof));
    cmp($sformatf("%s.eob", tag), 64'(tdd_endof_burst), 64'(eob));
    if (st == RUNNING)
      cmp($sformatf("%s.idx", tag), 64'(tdd_profile_idx), 64'(idx));
    if (st == RUNNING || st == WAITING)
      cmp($sformatf("%s.bc", tag), 64'(tdd_burst_counter), 64'(bc));
  endtask

  // Timeline model: n counts cycles from the first cycle after the sync edge.
  function automatic void model(input int n, output state_t st, output int cnt, output int idx,
                                output bit eof, output bit eob, output int bc);
    int pc, m, k, per;
    int len [NP];
    pc = (m_pc < 1) ? 1 : (m_pc > NP) ? NP : m_pc;
    foreach (len[i]) len[i] = (m_len[i] == 0) ? 1 : m_len[i];
    st = RUNNING; cnt = 0; idx = 0; eof = 0; eob = 0; bc = m_burst;
    per = m_delay;
    for (int j = 0; j < m_burst; j++) per += len[j % pc];
    m = n;
    if (m_burst != 0) begin
      if (m_rearm) m = n % per;
      else if (n >= per) begin
        st = ARMED;
        return;
      end
    end
    if (m < m_delay) begin
      st = WAITING;
      cnt = m;
      return;
    end
    m -= m_delay;
    k = 0;
    while (m >= len[k % pc]) begin
      m -= len[k % pc];
      k++;
    end
    cnt = m;
    idx = k % pc;
    eof = (m == len[idx] - 1);
    bc  = (m_burst == 0) ? 0 : m_burst - k;
    eob = (m_burst != 0) && eof && (k == m_burst - 1);
  endfunction

  task automatic drive_cfg();
    tdd_auto_rearm        = m_rearm;
    asy_tdd_burst_count   = BW'(m_burst);
    asy_tdd_startup_delay = RW'(m_delay);
    for (int i = 0; i < NP; i++) asy_tdd_frame_length[i*RW +: RW] = RW'(m_len[i]);
    asy_tdd_profile_count = (PIW+1)'(m_pc);
  endtask

  // Reset, load configuration, arm, sync; returns at n = 0.
  task automatic start();
    resetn = 1'b0; tdd_enable = 1'b0; tdd_sync = 1'b0; tdd_sync_rst = 1'b0;
    drive_cfg();
    tick(1);
    resetn = 1'b1; tdd_enable = 1'b1;
    tick(2);
    tdd_sync = 1'b1;
    tick(1);
    tdd_sync = 1'b0;
  endtask

  task automatic set_cfg(input logic [127:0] lens, input int pc, input int burst,
                         input int delay, input bit rearm);
    for (int i = 0; i < NP; i++) m_len[i] = int'(lens[i*32 +: 32]);
    m_pc = pc; m_burst = burst; m_delay = delay; m_rearm = rearm;
  endtask

  task automatic pulse_sync(input bit rst);
    tdd_sync = 1'b1; tdd_sync_rst = rst;
    tick(1);
    tdd_sync = 1'b0; tdd_sync_rst = 1'b0;
  endtask

  typedef struct {
    logic [127:0] lens;
    int pc, burst, delay;
    bit rearm;
    int n;
    state_t st;
    int cnt, idx;
    bit eof, eob;
    int bc;
  } vec_t;

  localparam logic [127:0] L_A = {32'd7, 32'd5, 32'd20, 32'd10};
  localparam logic [127:0] L_B = {32'd3, 32'd3, 32'd3, 32'd8};
  localparam logic [127:0] L_F = {32'd9, 32'd9, 32'd9, 32'd3};

  initial begin
    vec_t vecs[$];
    state_t st;
    int cnt, idx, bc;
    bit eof, eob;

    // Profiles 10,20,5 cycling, infinite burst
    vecs.push_back('{L_A, 3, 0, 0, 0,  0, RUNNING,  0, 0, 0, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0,  9, RUNNING,  9, 0, 1, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0, 10, RUNNING,  0, 1, 0, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0, 29, RUNNING, 19, 1, 1, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0, 34, RUNNING,  4, 2, 1, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0, 35, RUNNING,  0, 0, 0, 0, 0});
    vecs.push_back('{L_A, 3, 0, 0, 0, 44, RUNNING,  9, 0, 1, 0, 0});
    // Burst 2, delay 4, auto re-arm
    vecs.push_back('{L_B, 1, 2, 4, 1,  0, WAITING, 0, 0, 0, 0, 2});
    vecs.push_back('{L_B, 1, 2, 4, 1,  3, WAITING, 3, 0, 0, 0, 2});
    vecs.push_back('{L_B, 1, 2, 4, 1,  4, RUNNING, 0, 0, 0, 0, 2});
    vecs.push_back('{L_B, 1, 2, 4, 1, 11, RUNNING, 7, 0, 1, 0, 2});
    vecs.push_back('{L_B, 1, 2, 4, 1, 12, RUNNING, 0, 0, 0, 0, 1});
    vecs.push_back('{L_B, 1, 2, 4, 1, 19, RUNNING, 7, 0, 1, 1, 1});
    vecs.push_back('{L_B, 1, 2, 4, 1, 20, WAITING, 0, 0, 0, 0, 2});
    vecs.push_back('{L_B, 1, 2, 4, 1, 24, RUNNING, 0, 0, 0, 0, 2});
    // Same without re-arm
    vecs.push_back('{L_B, 1, 2, 4, 0, 19, RUNNING, 7, 0, 1, 1, 1});
    vecs.push_back('{L_B, 1, 2, 4, 0, 20, ARMED,   0, 0, 0, 0, 0});
    // Length 0 behaves as 1
    vecs.push_back('{128'd0, 1, 3, 0, 0, 0, RUNNING, 0, 0, 1, 0, 3});
    vecs.push_back('{128'd0, 1, 3, 0, 0, 1, RUNNING, 0, 0, 1, 0, 2});
    vecs.push_back('{128'd0, 1, 3, 0, 0, 2, RUNNING, 0, 0, 1, 1, 1});
    vecs.push_back('{128'd0, 1, 3, 0, 0, 3, ARMED,   0, 0, 0, 0, 0});
    // Profile count clamping: 0 -> 1, 7 -> 4
    vecs.push_back('{L_A, 0, 0, 0, 0, 10, RUNNING, 0, 0, 0, 0, 0});
    vecs.push_back('{L_A, 7, 0, 0, 0, 41, RUNNING, 6, 3, 1, 0, 0});
    vecs.push_back('{L_A, 7, 0, 0, 0, 42, RUNNING, 0, 0, 0, 0, 0});
    // Delay 1, single-frame burst with re-arm
    vecs.push_back('{L_F, 1, 1, 1, 1, 0, WAITING, 0, 0, 0, 0, 1});
    vecs.push_back('{L_F, 1, 1, 1, 1, 1, RUNNING, 0, 0, 0, 0, 1});
    vecs.push_back('{L_F, 1, 1, 1, 1, 3, RUNNING, 2, 0, 1, 1, 1});
    vecs.push_back('{L_F, 1, 1, 1, 1, 4, WAITING, 0, 0, 0, 0, 1});

    // Reset state
    tick(2);
    check_out("reset", IDLE, 0, 0, 0, 0, 0);
    cmp("reset.idx", 64'(tdd_profile_idx), 64'(0));
    cmp("reset.bc", 64'(tdd_burst_counter), 64'(0));

    foreach (vecs[v]) begin
      set_cfg(vecs[v].lens, vecs[v].pc, vecs[v].burst, vecs[v].delay, vecs[v].rearm);
      start();
      tick(vecs[v].n);
      check_out($sformatf("vec%0d", v), vecs[v].st, vecs[v].cnt, vecs[v].idx,
                vecs[v].eof, vecs[v].eob, vecs[v].bc);
    end

    // ARMED after burst; a late sync replays the same timeline
    set_cfg(L_B, 1, 2, 4, 0);
    start();
    tick(70);
    check_out("armed_wait", ARMED, 0, 0, 0, 0, 0);
    pulse_sync(1'b0);
    for (int j = 0; j < 25; j++) begin
      model(j, st, cnt, idx, eof, eob, bc);
      check_out($sformatf("resync%0d", j), st, cnt, idx, eof, eob, bc);
      tick(1);
    end

    // Disable mid-frame completes the frame
    set_cfg({96'd0, 32'd10}, 1, 0, 0, 0);
    start();
    tick(3);
    check_out("dis.c3", RUNNING, 3, 0, 0, 0, 0);
    tdd_enable = 1'b0;
    tick(6);
    check_out("dis.c9", RUNNING, 9, 0, 1, 0, 0);
    tick(1);
    check_out("dis.idle", IDLE, 0, 0, 0, 0, 0);

    // Disable in WAITING is immediate
    set_cfg({96'd0, 32'd10}, 1, 0, 10, 0);
    start();
    tick(2);
    check_out("disw.c2", WAITING, 2, 0, 0, 0, 0);
    tdd_enable = 1'b0;
    tick(1);
    check_out("disw.idle", IDLE, 0, 0, 0, 0, 0);

    // Frame re-sync in RUNNING, including on an end-of-frame cycle
    set_cfg({64'd0, 32'd10, 32'd4}, 2, 5, 0, 0);
    start();
    tick(10);
    check_out("rs.pre", RUNNING, 6, 1, 0, 0, 4);
    pulse_sync(1'b1);
    check_out("rs.post", RUNNING, 0, 0, 0, 0, 4);
    tick(3);
    check_out("rs.eof", RUNNING, 3, 0, 1, 0, 4);
    pulse_sync(1'b1);
    check_out("rs.over_eof", RUNNING, 0, 0, 0, 0, 4);
    pulse_sync(1'b0);
    check_out("rs.plain_sync", RUNNING, 1, 0, 0, 0, 4);
    tick(2);
    check_out("rs.eof2", RUNNING, 3, 0, 1, 0, 4);
    tick(1);
    check_out("rs.next", RUNNING, 0, 1, 0, 0, 3);

    // Re-sync in WAITING restarts the delay
    set_cfg({96'd0, 32'd5}, 1, 0, 6, 0);
    start();
    tick(3);
    check_out("rsw.pre", WAITING, 3, 0, 0, 0, 0);
    pulse_sync(1'b1);
    check_out("rsw.post", WAITING, 0, 0, 0, 0, 0);
    tick(5);
    check_out("rsw.last", WAITING, 5, 0, 0, 0, 0);
    tick(1);
    check_out("rsw.run", RUNNING, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    set_cfg(128'd0, 1, 100, 0, 0);
    start();
    tick(5);
    check_out("ar.pre", RUNNING, 0, 0, 1, 0, 95);
    resetn = 1'b0;
    #2;
    check_out("ar.post", IDLE, 0, 0, 0, 0, 0);
    cmp("ar.idx", 64'(tdd_profile_idx), 64'(0));
    cmp("ar.bc", 64'(tdd_burst_counter), 64'(0));
    tick(1);

    // Random configurations; asy_* scrambled after sync must have no effect
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NP; i++) m_len[i] = int'($urandom_range(0, 12));
      m_pc    = int'($urandom_range(0, 7));
      m_burst = int'($urandom_range(0, 3));
      m_delay = int'($urandom_range(0, 5));
      m_rearm = bit'($urandom_range(0, 1));
      start();
      for (int j = 0; j < 60; j++) begin
        model(j, st, cnt, idx, eof, eob, bc);
        check_out($sformatf("rnd%0d.%0d", it, j), st, cnt, idx, eof, eob, bc);
        asy_tdd_frame_length  = {$urandom, $urandom, $urandom, $urandom};
        asy_tdd_burst_count   = $urandom;
        asy_tdd_startup_delay = $urandom;
        asy_tdd_profile_count = (PIW+1)'($urandom);
        tick(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
